// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-ported data memory between the CPU data port
//   (requester 0) and a second bus master (requester 1). At most one access
//   is granted per cycle. Ties are broken round-robin. A requester can hold a
//   bounded lock so that a read-modify-write sequence cannot be interleaved.
//   Read data comes back with the memory's one-cycle latency.
//
// Ports
//   clk                   system clock; all state updates on posedge
//   rst                   synchronous reset, active-low
//   req0/req1             access request, held until granted
//   wr0/wr1               1 = write, 0 = read
//   addr0/addr1           access address
//   wdata0/wdata1         write data
//   lock0/lock1           keep exclusive ownership after this grant
//   gnt0/gnt1             combinational grant; access completes at this edge
//   rvalid0/rvalid1       rdata holds this requester's read result
//   rdata                 shared read data (memOut passed through)
//   memAddress/memIn      memory address / write data
//   memWrEnable           memory write strobe
//   memOut                memory read data, one cycle after the address
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock0,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memIn,
  output logic              memWrEnable,
  input  logic [DATA_W-1:0] memOut
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

  localparam logic [1:0] FREE  = 2'd0;
  localparam logic [1:0] LOCK0 = 2'd1;
  localparam logic [1:0] LOCK1 = 2'd2;

  logic [1:0]       lockState, nextState;
  logic             lastGnt, nextLastGnt;
  logic [CNT_W-1:0] lockCnt, nextCnt;
  logic             rvalid0Q, rvalid1Q;

  // Grant decision. Nothing is granted while reset is held, so no write can
  // reach the memory during a reset cycle.
  // NOTE: every signal assigned in an always_comb gets a default on entry;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
      case (lockState)
        LOCK0:   gnt0 = req0;
        LOCK1:   gnt1 = req1;
        default: begin
          if (req0 && req1) begin
            // Round-robin: the requester that was not served last wins.
            gnt0 = lastGnt;
            gnt1 = ~lastGnt;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
      endcase
    end
  end

  // Lock bookkeeping. The lock owner's own grants keep completing in the
  // release cycle; the other requester is only considered from the next cycle.
  always_comb begin
    nextState   = lockState;
    nextCnt     = lockCnt;
    nextLastGnt = lastGnt;
    if (gnt0)      nextLastGnt = 1'b0;
    else if (gnt1) nextLastGnt = 1'b1;

    case (lockState)
      LOCK0: begin
        nextCnt = lockCnt + CNT_W'(1);
        if (lockCnt == CNT_MAX) nextLastGnt = 1'b0;
        if (!lock0 || lockCnt == CNT_MAX) begin
          nextState = FREE;
          nextCnt   = '0;
        end
      end
      LOCK1: begin
        nextCnt = lockCnt + CNT_W'(1);
        if (lockCnt == CNT_MAX) nextLastGnt = 1'b1;
        if (!lock1 || lockCnt == CNT_MAX) begin
          nextState = FREE;
          nextCnt   = '0;
        end
      end
      default: begin
        if (gnt0 && lock0) begin
          nextState = LOCK0;
          nextCnt   = CNT_W'(1);
        end else if (gnt1 && lock1) begin
          nextState = LOCK1;
          nextCnt   = CNT_W'(1);
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lockState <= FREE;
      lastGnt   <= 1'b1;  // requester 0 wins the first tie
      lockCnt   <= '0;
      rvalid0Q  <= 1'b0;
      rvalid1Q  <= 1'b0;
    end else begin
      lockState <= nextState;
      lastGnt   <= nextLastGnt;
      lockCnt   <= nextCnt;
      rvalid0Q  <= gnt0 & ~wr0;
      rvalid1Q  <= gnt1 & ~wr1;
    end
  end

  // A read in flight when reset arrives is dropped: the flag is masked while
  // reset is held and the register itself is cleared at that edge.
  assign rvalid0 = rvalid0Q & rst;
  assign rvalid1 = rvalid1Q & rst;
  assign rdata   = memOut;

  // Memory drive: granted requester's access, all-zero when idle.
  always_comb begin
    memAddress  = '0;
    memIn       = '0;
    memWrEnable = 1'b0;
    if (gnt0) begin
      memAddress  = addr0;
      memIn       = wdata0;
      memWrEnable = wr0;
    end else if (gnt1) begin
      memAddress  = addr1;
      memIn       = wdata1;
      memWrEnable = wr1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed stimulus for mem_arbiter with an external memory model.
//   Expected read results are pushed into a scoreboard queue when a read is
//   issued; an independent monitor pops and compares on every rvalid pulse.
//   Grants and memory-side signals are compared directly by the stimulus.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, wr0, wr1, lock0, lock1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata, memAddress, memIn, memOut;
  logic       memWrEnable;
  logic       loadImg;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic       port;
    logic [7:0] data;
  } rdExp_t;

  rdExp_t sbQ[$];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .LOCK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .memAddress(memAddress), .memIn(memIn),
    .memWrEnable(memWrEnable), .memOut(memOut)
  );

  // Single-ported synchronous memory: write at the edge, read data one
  // cycle after the address. Image: 01=11, 02=22, 03=33, 20=5C, rest 0.
  logic [7:0] memArr [256];
  always @(posedge clk) begin
    if (loadImg) begin
      for (int i = 0; i < 256; i++) memArr[i] <= 8'h00;
      memArr[8'h01] <= 8'h11;
      memArr[8'h02] <= 8'h22;
      memArr[8'h03] <= 8'h33;
      memArr[8'h20] <= 8'h5C;
    end else if (memWrEnable) begin
      memArr[memAddress] <= memIn;
    end
    memOut <= memArr[memAddress];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per rvalid pulse.
  initial begin
    rdExp_t e;
    forever begin
      @(negedge clk);
      if (rvalid0 === 1'b1 || rvalid1 === 1'b1) begin
        if (sbQ.size() == 0) begin
          check("rvalid_unexpected", {30'd0, rvalid1, rvalid0}, 32'd0);
        end else begin
          e = sbQ.pop_front();
          check("rvalid_port", {30'd0, rvalid1, rvalid0}, e.port ? 32'd2 : 32'd1);
          check("rdata", {24'd0, rdata}, {24'd0, e.data});
        end
      end
    end
  end

  task automatic expectRd(input logic port, input logic [7:0] data);
    rdExp_t e;
    e.port = port;
    e.data = data;
    sbQ.push_back(e);
  endtask

  task automatic clearReqs();
    req0 = 0; wr0 = 0; lock0 = 0; addr0 = 8'h00; wdata0 = 8'h00;
    req1 = 0; wr1 = 0; lock1 = 0; addr1 = 8'h00; wdata1 = 8'h00;
  endtask

  task automatic rd0(input logic [7:0] a, input logic l);
    req0 = 1; wr0 = 0; addr0 = a; wdata0 = 8'h00; lock0 = l;
  endtask

  task automatic rd1(input logic [7:0] a, input logic l);
    req1 = 1; wr1 = 0; addr1 = a; wdata1 = 8'h00; lock1 = l;
  endtask

  // Wait until mid-cycle and compare the combinational grants.
  task automatic look(input string name, input logic e0, input logic e1);
    @(negedge clk);
    check({name, "_gnt0"}, {31'd0, gnt0}, {31'd0, e0});
    check({name, "_gnt1"}, {31'd0, gnt1}, {31'd0, e1});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 0;
    loadImg = 1;
    clearReqs();
    tick();
    loadImg = 0;

    // Reset held with both masters trying to write.
    req0 = 1; wr0 = 1; addr0 = 8'h10; wdata0 = 8'hFF;
    req1 = 1; wr1 = 1; addr1 = 8'h20; wdata1 = 8'hFF;
    look("reset", 0, 0);
    check("reset_we", {31'd0, memWrEnable}, 32'd0);
    check("reset_rvalid0", {31'd0, rvalid0}, 32'd0);
    check("reset_rvalid1", {31'd0, rvalid1}, 32'd0);
    tick();
    rst = 1;
    clearReqs();

    // Single writer: write 0x2A to 0x10, read it back.
    req0 = 1; wr0 = 1; addr0 = 8'h10; wdata0 = 8'h2A;
    look("wr0", 1, 0);
    check("wr0_we", {31'd0, memWrEnable}, 32'd1);
    check("wr0_addr", {24'd0, memAddress}, 32'h10);
    check("wr0_data", {24'd0, memIn}, 32'h2A);
    tick();
    rd0(8'h10, 0);
    expectRd(0, 8'h2A);
    look("rd0", 1, 0);
    check("rd0_we", {31'd0, memWrEnable}, 32'd0);
    tick();
    clearReqs();
    look("idle_after_rd0", 0, 0);
    check("idle_addr", {24'd0, memAddress}, 32'd0);
    tick();

    // Contention from reset: grants alternate 0,1,0,1.
    rst = 0;
    look("rst2", 0, 0);
    tick();
    rst = 1;
    rd0(8'h01, 0);
    rd1(8'h02, 0);
    for (int i = 0; i < 4; i++) begin
      expectRd(i[0], i[0] ? 8'h22 : 8'h11);
      look("contend", ~i[0], i[0]);
      tick();
    end
    clearReqs();

    // Lock RMW by requester 1 while requester 0 waits.
    rd0(8'h01, 0);                       // makes lastGnt = 0
    expectRd(0, 8'h11);
    look("pre_rmw", 1, 0);
    tick();
    rd0(8'h03, 0);
    rd1(8'h20, 1);
    expectRd(1, 8'h5C);
    look("rmw_read", 0, 1);
    tick();
    req1 = 1; wr1 = 1; wdata1 = 8'h21; lock1 = 0;
    look("rmw_write", 0, 1);
    check("rmw_we", {31'd0, memWrEnable}, 32'd1);
    check("rmw_addr", {24'd0, memAddress}, 32'h20);
    check("rmw_data", {24'd0, memIn}, 32'h21);
    tick();
    rd1(8'h20, 0);
    expectRd(0, 8'h33);
    look("rmw_after", 1, 0);
    tick();
    req0 = 0;
    expectRd(1, 8'h21);                  // written value is visible
    look("rmw_readback", 0, 1);
    tick();
    clearReqs();

    // Lock timeout: acquiring grant plus LOCK_MAX locked cycles, then forced
    // release; requester 0 wins the next tie.
    rd0(8'h01, 0);                       // makes lastGnt = 0
    expectRd(0, 8'h11);
    look("pre_timeout", 1, 0);
    tick();
    rd0(8'h03, 0);
    rd1(8'h02, 1);
    for (int i = 0; i < 5; i++) begin
      expectRd(1, 8'h22);
      look("timeout_hold", 0, 1);
      tick();
    end
    expectRd(0, 8'h33);
    look("timeout_release", 1, 0);
    tick();
    clearReqs();

    // Lock by requester 0; owner idle still blocks requester 1; then reset.
    rd0(8'h01, 1);
    expectRd(0, 8'h11);
    look("lock0_take", 1, 0);
    tick();
    req0 = 0;
    rd1(8'h02, 0);
    look("lock0_idle", 0, 0);
    tick();
    rd0(8'h03, 1);                       // read granted, result dropped by reset
    look("lock0_read", 1, 0);
    tick();
    rst = 0;
    req0 = 1; wr0 = 1; addr0 = 8'h03; wdata0 = 8'hEE;
    look("rst_midlock", 0, 0);
    check("rst_midlock_we", {31'd0, memWrEnable}, 32'd0);
    check("rst_midlock_rvalid0", {31'd0, rvalid0}, 32'd0);
    tick();
    rst = 1;
    rd0(8'h03, 0);
    expectRd(0, 8'h33);                  // no write happened during reset
    look("post_rst_tie", 1, 0);
    tick();
    req0 = 0;
    expectRd(1, 8'h22);
    look("post_rst_r1", 0, 1);
    tick();
    clearReqs();

    // Idle.
    for (int i = 0; i < 10; i++) begin
      look("idle", 0, 0);
      check("idle_we", {31'd0, memWrEnable}, 32'd0);
      check("idle_addr", {24'd0, memAddress}, 32'd0);
      check("idle_wdata", {24'd0, memIn}, 32'd0);
      if (i > 0) begin
        check("idle_rvalid0", {31'd0, rvalid0}, 32'd0);
        check("idle_rvalid1", {31'd0, rvalid1}, 32'd0);
      end
      tick();
    end

    check("sb_drained", sbQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
